fractal_scan_gen: RTL and testbench

Parametrised pixel-scan generator for the Mandelbrot datapath. Walks a COLS×ROWS frame in row-major order, issues one (x, y) coordinate every ISSUE_INTERVAL cycles into stage 0 of the `diverge_pipe` chain, and delays each pixel's frame-buffer address by PIPE_LATENCY cycles so that `wea`/`addr_w` line up with the iteration count leaving the last stage. Adds start/busy/done handshaking, single-shot or continuous frame modes, and multiplier-free coordinate accumulation.

---
 rtl/fractal_scan_gen_pkg.sv | 22 ++
 rtl/fractal_scan_gen_if.sv | 32 +++
 rtl/fractal_scan_gen_pipe_delay.sv | 35 +++
 rtl/fractal_scan_gen.sv | 151 +++++++++++++++
 tb/tb_fractal_scan_gen.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fractal_scan_gen_pkg.sv
// Shared defaults and scan-state encoding for the Mandelbrot pixel-scan generator.
package fractal_scan_gen_pkg;

    localparam int unsigned DEF_COLS           = 640;
    localparam int unsigned DEF_ROWS           = 480;
    localparam int unsigned DEF_COORD_W        = 16;
    localparam int unsigned DEF_ADDR_W         = 19;
    localparam int unsigned DEF_ISSUE_INTERVAL = 6;
    localparam int unsigned DEF_PIPE_LATENCY   = 63;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } scan_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fractal_scan_gen_if.sv
// Control, coordinate and frame-buffer write signals of the scan generator.
interface fractal_scan_gen_if import fractal_scan_gen_pkg::*; #(
    parameter int unsigned COORD_W = DEF_COORD_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W
) ();

    logic               start;
    logic               continuous;
    logic [COORD_W-1:0] startX;
    logic [COORD_W-1:0] startY;
    logic [COORD_W-1:0] stepX;
    logic [COORD_W-1:0] stepY;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               pix_valid;
    logic [ADDR_W-1:0]  addr_w;
    logic               wea;
    logic               busy;
    logic               frame_done;
    logic               display;

    modport master (
        output start, continuous, startX, startY, stepX, stepY,
        input  pix_x, pix_y, pix_valid, addr_w, wea, busy, frame_done, display
    );

    modport slave (
        input  start, continuous, startX, startY, stepX, stepY,
        output pix_x, pix_y, pix_valid, addr_w, wea, busy, frame_done, display
    );

endinterface

// File: rtl/fractal_scan_gen_pipe_delay.sv
// Fixed-depth shift register with synchronous active-low clear; tail_c is the
// value that will appear on q after the next edge.
module fractal_scan_gen_pipe_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] tail_c
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_tail_in
            assign tail_c = d;
        end else begin : g_tail_stage
            assign tail_c = stage[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/fractal_scan_gen.sv
// Row-major pixel-scan generator: issues coordinates to the divergence pipe and
// delays each pixel's frame-buffer address to line up with the pipe output.
module fractal_scan_gen import fractal_scan_gen_pkg::*; #(
    parameter int unsigned COLS           = DEF_COLS,
    parameter int unsigned ROWS           = DEF_ROWS,
    parameter int unsigned COORD_W        = DEF_COORD_W,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned ISSUE_INTERVAL = DEF_ISSUE_INTERVAL,
    parameter int unsigned PIPE_LATENCY   = DEF_PIPE_LATENCY
) (
    input logic                Clk_100M,
    input logic                reset,
    fractal_scan_gen_if.slave  bus
);

    localparam int unsigned COL_W = width_of(COLS);
    localparam int unsigned ROW_W = width_of(ROWS);
    localparam int unsigned CNT_W = width_of(ISSUE_INTERVAL);
    localparam int unsigned PAY_W = ADDR_W + 1;

    scan_state_t state, state_next;
    logic        issue_c, load_c, last_pix_c, tail_done_c;

    logic [CNT_W-1:0]   cnt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  addr, issue_addr;
    logic [COORD_W-1:0] x_acc, y_acc, start_x_q, step_x_q, step_y_q;
    logic [COORD_W-1:0] pix_x_q, pix_y_q;
    logic               cont_q, pix_valid_q, busy_q, frame_done_q, display_q;
    logic [PAY_W-1:0]   pay_q, pay_tail_c;

    assign last_pix_c  = (col == COL_W'(COLS - 1)) && (row == ROW_W'(ROWS - 1));
    // Final pixel's write one cycle before it leaves the delay line.
    assign tail_done_c = pay_tail_c[ADDR_W] &&
                         (pay_tail_c[ADDR_W-1:0] == ADDR_W'(COLS * ROWS - 1));

    always_ff @(posedge Clk_100M) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue_c    = 1'b0;
        load_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    load_c     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    issue_c = 1'b1;
                    if (last_pix_c) begin
                        if (cont_q) load_c     = 1'b1;
                        else        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (tail_done_c) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_100M) begin
        if (!reset) begin
            cnt          <= '0;
            col          <= '0;
            row          <= '0;
            addr         <= '0;
            issue_addr   <= '0;
            x_acc        <= '0;
            y_acc        <= '0;
            start_x_q    <= '0;
            step_x_q     <= '0;
            step_y_q     <= '0;
            cont_q       <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            display_q    <= 1'b0;
        end else begin
            pix_valid_q  <= issue_c;
            busy_q       <= (state != S_IDLE);
            frame_done_q <= tail_done_c;
            display_q    <= display_q | tail_done_c;

            if (state == S_RUN) begin
                cnt <= (cnt == CNT_W'(ISSUE_INTERVAL - 1)) ? '0 : cnt + CNT_W'(1);
            end

            if (issue_c) begin
                pix_x_q    <= x_acc;
                pix_y_q    <= y_acc;
                issue_addr <= addr;
                addr       <= addr + ADDR_W'(1);
                if (col != COL_W'(COLS - 1)) begin
                    col   <= col + COL_W'(1);
                    x_acc <= x_acc + step_x_q;
                end else begin
                    col   <= '0;
                    x_acc <= start_x_q;
                    row   <= row + ROW_W'(1);
                    y_acc <= y_acc + step_y_q;
                end
            end

            // A (re)latch overrides the scan advance; cadence only restarts from IDLE.
            if (load_c) begin
                start_x_q <= bus.startX;
                step_x_q  <= bus.stepX;
                step_y_q  <= bus.stepY;
                cont_q    <= bus.continuous;
                x_acc     <= bus.startX;
                y_acc     <= bus.startY;
                col       <= '0;
                row       <= '0;
                addr      <= '0;
                if (state == S_IDLE) cnt <= '0;
            end
        end
    end

    fractal_scan_gen_pipe_delay #(
        .WIDTH (PAY_W),
        .DEPTH (PIPE_LATENCY)
    ) u_write_delay (
        .clk    (Clk_100M),
        .clr_n  (reset),
        .d      ({pix_valid_q, issue_addr}),
        .q      (pay_q),
        .tail_c (pay_tail_c)
    );

    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.wea        = pay_q[ADDR_W];
    assign bus.addr_w     = pay_q[ADDR_W-1:0];
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.display    = display_q;

endmodule

// File: tb/tb_fractal_scan_gen.sv
// Directed bench: a 4x3 frame on two configurations (interval 2 / latency 5 and 1 / 1).
module tb_fractal_scan_gen;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fractal_scan_gen_if #(.COORD_W(16), .ADDR_W(19)) bus_a ();
    fractal_scan_gen_if #(.COORD_W(16), .ADDR_W(19)) bus_b ();

    fractal_scan_gen #(
        .COLS(4), .ROWS(3), .COORD_W(16), .ADDR_W(19),
        .ISSUE_INTERVAL(2), .PIPE_LATENCY(5)
    ) dut_a (.Clk_100M(clk), .reset(reset), .bus(bus_a));

    fractal_scan_gen #(
        .COLS(4), .ROWS(3), .COORD_W(16), .ADDR_W(19),
        .ISSUE_INTERVAL(1), .PIPE_LATENCY(1)
    ) dut_b (.Clk_100M(clk), .reset(reset), .bus(bus_b));

    typedef struct {
        int          cyc;
        logic [18:0] a;
        logic [15:0] x;
        logic [15:0] y;
    } ev_t;

    typedef struct {
        int          k;
        logic [15:0] ex;
        logic [15:0] ey;
    } vec_t;

    ev_t  iss_a[$], wea_a[$], iss_b[$], wea_b[$];
    int   fd_a[$], fd_b[$], bf_a[$], bf_b[$];
    logic bp_a = 1'b0, bp_b = 1'b0;
    vec_t base_tbl[12];
    vec_t wrap_tbl[12];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   t0;

    // Event log sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus_a.pix_valid === 1'b1) iss_a.push_back('{cyc, 19'd0, bus_a.pix_x, bus_a.pix_y});
        if (bus_a.wea === 1'b1)       wea_a.push_back('{cyc, bus_a.addr_w, 16'd0, 16'd0});
        if (bus_a.frame_done === 1'b1) fd_a.push_back(cyc);
        if (bp_a && bus_a.busy === 1'b0) bf_a.push_back(cyc);
        bp_a = (bus_a.busy === 1'b1);
        if (bus_b.pix_valid === 1'b1) iss_b.push_back('{cyc, 19'd0, bus_b.pix_x, bus_b.pix_y});
        if (bus_b.wea === 1'b1)       wea_b.push_back('{cyc, bus_b.addr_w, 16'd0, 16'd0});
        if (bus_b.frame_done === 1'b1) fd_b.push_back(cyc);
        if (bp_b && bus_b.busy === 1'b0) bf_b.push_back(cyc);
        bp_b = (bus_b.busy === 1'b1);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        iss_a.delete(); wea_a.delete(); fd_a.delete(); bf_a.delete();
        iss_b.delete(); wea_b.delete(); fd_b.delete(); bf_b.delete();
    endtask

    task automatic set_a(input logic [15:0] sx, input logic [15:0] stx,
                         input logic [15:0] sy, input logic [15:0] sty, input logic cont);
        bus_a.startX = sx; bus_a.stepX = stx;
        bus_a.startY = sy; bus_a.stepY = sty;
        bus_a.continuous = cont;
    endtask

    task automatic pulse_start_a(output int ts);
        @(negedge clk);
        bus_a.start = 1'b1;
        ts = cyc;
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    task automatic check_issues_a(input vec_t tbl[12], input int first, input int t_first,
                                  input logic [15:0] xoff, input string tag);
        for (int j = 0; j < 12; j++) begin
            int          idx;
            logic [15:0] ex;
            idx = first + j;
            ex  = tbl[j].ex + xoff;
            if (idx < iss_a.size()) begin
                chk($sformatf("%s k=%0d issue cycle", tag, tbl[j].k), iss_a[idx].cyc, t_first + 2 * j);
                chk($sformatf("%s k=%0d pix_x", tag, tbl[j].k), iss_a[idx].x, ex);
                chk($sformatf("%s k=%0d pix_y", tag, tbl[j].k), iss_a[idx].y, tbl[j].ey);
            end else begin
                chk($sformatf("%s k=%0d issue count", tag, tbl[j].k), iss_a.size(), idx + 1);
            end
        end
    endtask

    task automatic check_wea_a(input int first, input int t_first, input string tag);
        for (int j = 0; j < 12; j++) begin
            int idx;
            idx = first + j;
            if (idx < wea_a.size()) begin
                chk($sformatf("%s wea %0d cycle", tag, j), wea_a[idx].cyc, t_first + 2 * j);
                chk($sformatf("%s wea %0d addr_w", tag, j), wea_a[idx].a, j);
            end else begin
                chk($sformatf("%s wea %0d count", tag, j), wea_a.size(), idx + 1);
            end
        end
    endtask

    initial begin
        base_tbl = '{'{0, 16'h1000, 16'h2000}, '{1, 16'h1010, 16'h2000},
                     '{2, 16'h1020, 16'h2000}, '{3, 16'h1030, 16'h2000},
                     '{4, 16'h1000, 16'h2020}, '{5, 16'h1010, 16'h2020},
                     '{6, 16'h1020, 16'h2020}, '{7, 16'h1030, 16'h2020},
                     '{8, 16'h1000, 16'h2040}, '{9, 16'h1010, 16'h2040},
                     '{10, 16'h1020, 16'h2040}, '{11, 16'h1030, 16'h2040}};
        wrap_tbl = '{'{0, 16'hFFF0, 16'h0000}, '{1, 16'h0000, 16'h0000},
                     '{2, 16'h0010, 16'h0000}, '{3, 16'h0020, 16'h0000},
                     '{4, 16'hFFF0, 16'h0001}, '{5, 16'h0000, 16'h0001},
                     '{6, 16'h0010, 16'h0001}, '{7, 16'h0020, 16'h0001},
                     '{8, 16'hFFF0, 16'h0002}, '{9, 16'h0000, 16'h0002},
                     '{10, 16'h0010, 16'h0002}, '{11, 16'h0020, 16'h0002}};

        // Reset held with start asserted: everything stays at zero.
        reset = 1'b0;
        set_a(16'h1000, 16'h0010, 16'h2000, 16'h0020, 1'b0);
        bus_a.start = 1'b1;
        bus_b.start = 1'b1; bus_b.continuous = 1'b0;
        bus_b.startX = 16'h1000; bus_b.stepX = 16'h0010;
        bus_b.startY = 16'h2000; bus_b.stepY = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset pix_valid", bus_a.pix_valid, 0);
            chk("reset busy", bus_a.busy, 0);
            chk("reset wea", bus_a.wea, 0);
            chk("reset frame_done", bus_a.frame_done, 0);
            chk("reset display", bus_a.display, 0);
            chk("reset pix_x", bus_a.pix_x, 0);
            chk("reset pix_y", bus_a.pix_y, 0);
            chk("reset addr_w", bus_a.addr_w, 0);
            chk("reset b pix_valid", bus_b.pix_valid, 0);
            chk("reset b busy", bus_b.busy, 0);
        end
        reset = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        run(2);
        chk("no issue out of reset", iss_a.size() + iss_b.size(), 0);
        clear_q();

        // Single frame, interval 2, latency 5.
        set_a(16'h1000, 16'h0010, 16'h2000, 16'h0020, 1'b0);
        pulse_start_a(t0);
        run(50);
        chk("single issue count", iss_a.size(), 12);
        check_issues_a(base_tbl, 0, t0 + 2, 16'h0000, "single");
        check_wea_a(0, t0 + 7, "single");
        chk("single frame_done count", fd_a.size(), 1);
        chk("single frame_done cycle", (fd_a.size() > 0) ? fd_a[0] : -1, t0 + 29);
        chk("single busy fall cycle", (bf_a.size() > 0) ? bf_a[0] : -1, t0 + 30);
        chk("single display", bus_a.display, 1);
        chk("single busy idle", bus_a.busy, 0);
        clear_q();

        // Coordinate wrap, with a start pulse mid-frame that must be ignored.
        set_a(16'hFFF0, 16'h0010, 16'h0000, 16'h0001, 1'b0);
        pulse_start_a(t0);
        run(4);
        bus_a.start = 1'b1;
        run(1);
        chk("wrap busy during run", bus_a.busy, 1);
        bus_a.start = 1'b0;
        run(50);
        chk("wrap issue count", iss_a.size(), 12);
        check_issues_a(wrap_tbl, 0, t0 + 2, 16'h0000, "wrap");
        chk("wrap busy fall count", bf_a.size(), 1);
        chk("wrap busy fall cycle", (bf_a.size() > 0) ? bf_a[0] : -1, t0 + 30);
        clear_q();

        // Continuous: new startX and continuous=0 mid-frame apply to frame 2 only.
        set_a(16'h1000, 16'h0010, 16'h2000, 16'h0020, 1'b1);
        pulse_start_a(t0);
        run(9);
        bus_a.startX = 16'h3000;
        bus_a.continuous = 1'b0;
        run(70);
        chk("cont issue count", iss_a.size(), 24);
        check_issues_a(base_tbl, 0, t0 + 2, 16'h0000, "cont f1");
        check_issues_a(base_tbl, 12, t0 + 26, 16'h2000, "cont f2");
        check_wea_a(0, t0 + 7, "cont f1");
        check_wea_a(12, t0 + 31, "cont f2");
        chk("cont frame_done count", fd_a.size(), 2);
        chk("cont frame_done 1 cycle", (fd_a.size() > 0) ? fd_a[0] : -1, t0 + 29);
        chk("cont frame_done 2 cycle", (fd_a.size() > 1) ? fd_a[1] : -1, t0 + 53);
        chk("cont busy fall count", bf_a.size(), 1);
        chk("cont busy fall cycle", (bf_a.size() > 0) ? bf_a[0] : -1, t0 + 54);
        clear_q();

        // Reset mid-frame: in-flight pixels never produce a write.
        set_a(16'h1000, 16'h0010, 16'h2000, 16'h0020, 1'b0);
        pulse_start_a(t0);
        run(4);
        reset = 1'b0;
        run(2);
        reset = 1'b1;
        run(30);
        chk("midreset issue count", iss_a.size(), 2);
        chk("midreset wea count", wea_a.size(), 0);
        chk("midreset frame_done count", fd_a.size(), 0);
        chk("midreset display", bus_a.display, 0);
        chk("midreset busy", bus_a.busy, 0);
        chk("midreset pix_x", bus_a.pix_x, 0);
        clear_q();

        // Interval 1, latency 1: back-to-back issues and writes.
        @(negedge clk);
        bus_b.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus_b.start = 1'b0;
        run(30);
        chk("ii1 issue count", iss_b.size(), 12);
        chk("ii1 wea count", wea_b.size(), 12);
        for (int j = 0; j < 12; j++) begin
            if (j < iss_b.size()) begin
                chk($sformatf("ii1 k=%0d issue cycle", j), iss_b[j].cyc, t0 + 2 + j);
                chk($sformatf("ii1 k=%0d pix_x", j), iss_b[j].x, base_tbl[j].ex);
                chk($sformatf("ii1 k=%0d pix_y", j), iss_b[j].y, base_tbl[j].ey);
            end
            if (j < wea_b.size()) begin
                chk($sformatf("ii1 wea %0d cycle", j), wea_b[j].cyc, t0 + 3 + j);
                chk($sformatf("ii1 wea %0d addr_w", j), wea_b[j].a, j);
            end
        end
        chk("ii1 frame_done cycle", (fd_b.size() > 0) ? fd_b[0] : -1, t0 + 14);
        chk("ii1 busy fall cycle", (bf_b.size() > 0) ? bf_b[0] : -1, t0 + 15);
        chk("ii1 display", bus_b.display, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
